// File: rtl/shift_rx_8bit.sv
// shift_rx_8bit: serial-in / parallel-out receiver that reassembles a strobed bit stream into words.
// Latency: the completed word is in p_out/p_valid the cycle after the edge that samples its last bit.
// Backpressure: one-word holding register (valid/ready); a word finishing while it is full and not
//   being drained is dropped and raises sticky overrun.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   s_in, s_valid        serial bit and its per-bit strobe
//   frame_clr            discard the partial word (wins over s_valid)
//   p_out, p_valid       holding register contents and its occupied flag
//   p_ready              consumer accepts p_out when p_valid & p_ready at an edge
//   busy, bit_cnt        partial-word status
//   overrun, ovr_clr     sticky word-dropped flag and its clear
module shift_rx_8bit #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_in,
  input  logic                     s_valid,
  input  logic                     frame_clr,
  output logic [WIDTH-1:0]         p_out,
  output logic                     p_valid,
  input  logic                     p_ready,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic             take;
  logic             done;
  logic             load;
  logic             drop;

  // A bit is accepted only when not being re-framed in the same cycle.
  assign take = s_valid & ~frame_clr;
  assign done = take & (bit_cnt == LAST);

  // Shift register contents after this cycle's bit; on completion this is the word itself.
  always_comb begin
    word = shreg;
    if (LSB_FIRST) begin
      word = {s_in, shreg[WIDTH-1:1]};
    end else begin
      word = {shreg[WIDTH-2:0], s_in};
    end
  end

  // Holding register control.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (done) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (done) begin
          // Drain and refill on the same edge keeps the register full without loss.
          if (p_ready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (p_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (frame_clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (s_valid) begin
      shreg   <= word;
      bit_cnt <= done ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_out <= '0;
    end else if (load) begin
      p_out <= word;
    end
  end

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

  assign p_valid = (state == FULL);
  assign busy    = (bit_cnt != '0);

endmodule
